// File: rtl/ex_mem_reg_pkg.sv
// Shared widths, RISC-V opcode/funct3 codes and byte-enable constants for
// the EX/MEM stage register and its store/load lane formatter.
package ex_mem_reg_pkg;

    localparam int WORD_DATA    = 32;
    localparam int WORD_ADDR    = 32;
    localparam int RISCV_OPCODE = 7;
    localparam int RISCV_FUNCT3 = 3;
    localparam int RISCV_RD     = 5;
    localparam int RISCV_RS1    = 5;
    localparam int RISCV_RS2    = 5;

    typedef logic [3:0] BYTE_EN;
    localparam BYTE_EN BE_NONE = 4'b0000;
    localparam BYTE_EN BE_WORD = 4'b1111;

    localparam logic [RISCV_OPCODE-1:0] INS_TYPE_L = 7'b0000011;
    localparam logic [RISCV_OPCODE-1:0] INS_TYPE_S = 7'b0100011;

    localparam logic [RISCV_FUNCT3-1:0] INS_LB  = 3'b000;
    localparam logic [RISCV_FUNCT3-1:0] INS_LH  = 3'b001;
    localparam logic [RISCV_FUNCT3-1:0] INS_LW  = 3'b010;
    localparam logic [RISCV_FUNCT3-1:0] INS_LBU = 3'b100;
    localparam logic [RISCV_FUNCT3-1:0] INS_LHU = 3'b101;
    localparam logic [RISCV_FUNCT3-1:0] INS_SB  = 3'b000;
    localparam logic [RISCV_FUNCT3-1:0] INS_SH  = 3'b001;
    localparam logic [RISCV_FUNCT3-1:0] INS_SW  = 3'b010;

    // Contents of the stage register; an all-zero value is a bubble.
    typedef struct packed {
        logic                    valid;
        logic                    wb_en;
        logic                    we;
        logic [WORD_DATA-1:0]    data;
        logic [WORD_ADDR-1:0]    mem_addr;
        logic [RISCV_OPCODE-1:0] opcode;
        logic [RISCV_FUNCT3-1:0] funct3;
        logic [RISCV_RD-1:0]     rd;
        logic [RISCV_RS1-1:0]    rs1;
        logic [RISCV_RS2-1:0]    rs2;
        BYTE_EN                  be;
        logic                    misalign;
    } exmem_t;

endpackage

// File: rtl/ex_mem_reg_store_align.sv
// Combinational lane formatter: byte enables, replicated store data and
// misalignment detection for loads/stores. Misaligned accesses get BE_NONE.
module store_align
    import ex_mem_reg_pkg::*;
(
    input  logic [RISCV_OPCODE-1:0] i_opcode,
    input  logic [RISCV_FUNCT3-1:0] i_funct3,
    input  logic [1:0]              i_addr_lo,
    input  logic [WORD_DATA-1:0]    i_rs2,
    output BYTE_EN                  o_be,
    output logic [WORD_DATA-1:0]    o_data,
    output logic                    o_misalign
);

    BYTE_EN w_be;
    BYTE_EN w_be_byte;
    BYTE_EN w_be_half;

    assign w_be_byte = 4'b0001 << i_addr_lo;
    assign w_be_half = i_addr_lo[1] ? 4'b1100 : 4'b0011;

    always_comb begin
        w_be       = BE_NONE;
        o_data     = i_rs2;
        o_misalign = 1'b0;
        if (i_opcode == INS_TYPE_S) begin
            case (i_funct3)
                INS_SB: begin
                    w_be   = w_be_byte;
                    o_data = {4{i_rs2[7:0]}};
                end
                INS_SH: begin
                    w_be       = w_be_half;
                    o_data     = {2{i_rs2[15:0]}};
                    o_misalign = i_addr_lo[0];
                end
                INS_SW: begin
                    w_be       = BE_WORD;
                    o_misalign = (i_addr_lo != 2'b00);
                end
                default: w_be = BE_NONE;
            endcase
        end else if (i_opcode == INS_TYPE_L) begin
            case (i_funct3)
                INS_LB, INS_LBU: w_be = w_be_byte;
                INS_LH, INS_LHU: begin
                    w_be       = w_be_half;
                    o_misalign = i_addr_lo[0];
                end
                INS_LW: begin
                    w_be       = BE_WORD;
                    o_misalign = (i_addr_lo != 2'b00);
                end
                default: w_be = BE_NONE;
            endcase
        end
    end

    assign o_be = o_misalign ? BE_NONE : w_be;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: formats store lanes and byte enables, flags
// misaligned accesses, honours stall/flush and feeds forwarding back to EX.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex2exmem_valid_i,
    input  logic                    ex2exmem_wb_en_i,
    input  logic                    ex2exmem_we_i,
    input  logic [WORD_DATA-1:0]    ex2exmem_data_i,
    input  logic [WORD_ADDR-1:0]    ex2exmem_mem_addr_i,
    input  logic [RISCV_OPCODE-1:0] ex2exmem_opcode_i,
    input  logic [RISCV_FUNCT3-1:0] ex2exmem_funct3_i,
    input  logic [RISCV_RD-1:0]     ex2exmem_rd_i,
    input  logic [RISCV_RS1-1:0]    ex2exmem_rs1_i,
    input  logic [RISCV_RS2-1:0]    ex2exmem_rs2_i,
    input  logic                    ctrl2exmem_stall_i,
    input  logic                    ctrl2exmem_flush_i,
    output logic                    exmem2mem_valid_o,
    output logic                    exmem2mem_wb_en_o,
    output logic                    exmem2mem_we_o,
    output logic [WORD_DATA-1:0]    exmem2mem_data_o,
    output logic [WORD_ADDR-1:0]    exmem2mem_mem_addr_o,
    output logic [RISCV_OPCODE-1:0] exmem2mem_opcode_o,
    output logic [RISCV_FUNCT3-1:0] exmem2mem_funct3_o,
    output logic [RISCV_RD-1:0]     exmem2mem_rd_o,
    output logic [RISCV_RS1-1:0]    exmem2mem_rs1_o,
    output logic [RISCV_RS2-1:0]    exmem2mem_rs2_o,
    output BYTE_EN                  exmem2mem_be_o,
    output logic                    exmem2ctrl_misalign_o,
    output logic                    exmem2ex_fwd_valid_o,
    output logic [RISCV_RD-1:0]     exmem2ex_fwd_rd_o,
    output logic [WORD_DATA-1:0]    exmem2ex_fwd_data_o,
    output logic                    exmem2ctrl_load_pending_o
);

    exmem_t                 r_stage;
    exmem_t                 w_next;
    BYTE_EN                 w_be;
    logic [WORD_DATA-1:0]   w_data;
    logic                   w_misalign;
    logic                   w_is_ls;
    logic                   w_kill;

    store_align u_store_align (
        .i_opcode   (ex2exmem_opcode_i),
        .i_funct3   (ex2exmem_funct3_i),
        .i_addr_lo  (ex2exmem_mem_addr_i[1:0]),
        .i_rs2      (ex2exmem_data_i),
        .o_be       (w_be),
        .o_data     (w_data),
        .o_misalign (w_misalign)
    );

    // A legal load/store always has a nonzero byte enable, so BE_NONE under
    // L/S means misaligned or unknown funct3: suppress both enables.
    assign w_is_ls = (ex2exmem_opcode_i == INS_TYPE_L) || (ex2exmem_opcode_i == INS_TYPE_S);
    assign w_kill  = w_is_ls && (w_be == BE_NONE);

    always_comb begin
        w_next = '0;
        if (ex2exmem_valid_i) begin
            w_next.valid    = 1'b1;
            w_next.wb_en    = ex2exmem_wb_en_i & ~w_kill;
            w_next.we       = ex2exmem_we_i & ~w_kill;
            w_next.data     = w_data;
            w_next.mem_addr = ex2exmem_mem_addr_i;
            w_next.opcode   = ex2exmem_opcode_i;
            w_next.funct3   = ex2exmem_funct3_i;
            w_next.rd       = ex2exmem_rd_i;
            w_next.rs1      = ex2exmem_rs1_i;
            w_next.rs2      = ex2exmem_rs2_i;
            w_next.be       = w_be;
            w_next.misalign = w_misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else if (ctrl2exmem_flush_i) begin
            r_stage <= '0;
        end else if (!ctrl2exmem_stall_i) begin
            r_stage <= w_next;
        end
    end

    assign exmem2mem_valid_o     = r_stage.valid;
    assign exmem2mem_wb_en_o     = r_stage.wb_en;
    assign exmem2mem_we_o        = r_stage.we;
    assign exmem2mem_data_o      = r_stage.data;
    assign exmem2mem_mem_addr_o  = r_stage.mem_addr;
    assign exmem2mem_opcode_o    = r_stage.opcode;
    assign exmem2mem_funct3_o    = r_stage.funct3;
    assign exmem2mem_rd_o        = r_stage.rd;
    assign exmem2mem_rs1_o       = r_stage.rs1;
    assign exmem2mem_rs2_o       = r_stage.rs2;
    assign exmem2mem_be_o        = r_stage.be;
    assign exmem2ctrl_misalign_o = r_stage.misalign;

    assign exmem2ex_fwd_valid_o = r_stage.valid & r_stage.wb_en & (r_stage.rd != '0)
                                & (r_stage.opcode != INS_TYPE_L);
    assign exmem2ex_fwd_rd_o    = r_stage.rd;
    assign exmem2ex_fwd_data_o  = r_stage.mem_addr;
    assign exmem2ctrl_load_pending_o = r_stage.valid & (r_stage.opcode == INS_TYPE_L)
                                     & (r_stage.rd != '0) & ~r_stage.misalign;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed table-driven bench for ex_mem_reg plus hand-written stall/flush sequences.
module tb_ex_mem_reg;

    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n, valid, wb_en, we, stall, flush;
    logic [31:0] data, addr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;

    logic        o_valid, o_wb_en, o_we, o_mis, o_fv, o_lp;
    logic [31:0] o_data, o_addr, o_fdata;
    logic [6:0]  o_opcode;
    logic [2:0]  o_funct3;
    logic [4:0]  o_rd, o_rs1, o_rs2, o_frd;
    logic [3:0]  o_be;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .ex2exmem_valid_i          (valid),
        .ex2exmem_wb_en_i          (wb_en),
        .ex2exmem_we_i             (we),
        .ex2exmem_data_i           (data),
        .ex2exmem_mem_addr_i       (addr),
        .ex2exmem_opcode_i         (opcode),
        .ex2exmem_funct3_i         (funct3),
        .ex2exmem_rd_i             (rd),
        .ex2exmem_rs1_i            (rs1),
        .ex2exmem_rs2_i            (rs2),
        .ctrl2exmem_stall_i        (stall),
        .ctrl2exmem_flush_i        (flush),
        .exmem2mem_valid_o         (o_valid),
        .exmem2mem_wb_en_o         (o_wb_en),
        .exmem2mem_we_o            (o_we),
        .exmem2mem_data_o          (o_data),
        .exmem2mem_mem_addr_o      (o_addr),
        .exmem2mem_opcode_o        (o_opcode),
        .exmem2mem_funct3_o        (o_funct3),
        .exmem2mem_rd_o            (o_rd),
        .exmem2mem_rs1_o           (o_rs1),
        .exmem2mem_rs2_o           (o_rs2),
        .exmem2mem_be_o            (o_be),
        .exmem2ctrl_misalign_o     (o_mis),
        .exmem2ex_fwd_valid_o      (o_fv),
        .exmem2ex_fwd_rd_o         (o_frd),
        .exmem2ex_fwd_data_o       (o_fdata),
        .exmem2ctrl_load_pending_o (o_lp)
    );

    typedef struct {
        logic        rst_n, stall, flush, valid, wb_en, we;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] addr, rs2v;
        logic [4:0]  rd;
        logic        e_valid, e_we, e_wb;
        logic [3:0]  e_be;
        logic [31:0] e_data;
        logic        e_mis, e_fv, e_lp;
        logic [31:0] e_addr;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t tv[21];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic fl, input logic v,
                         input logic wb, input logic w, input logic [6:0] op, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdi);
        rst_n = r; stall = st; flush = fl; valid = v; wb_en = wb; we = w;
        opcode = op; funct3 = f; addr = a; data = d; rd = rdi;
        rs1 = 5'd1; rs2 = 5'd2;
    endtask

    task automatic run_vec(input int i);
        drive(tv[i].rst_n, tv[i].stall, tv[i].flush, tv[i].valid, tv[i].wb_en, tv[i].we,
              tv[i].opc, tv[i].f3, tv[i].addr, tv[i].rs2v, tv[i].rd);
        @(posedge clk); #1;
        check("valid",    i, {31'd0, o_valid}, {31'd0, tv[i].e_valid});
        check("we",       i, {31'd0, o_we},    {31'd0, tv[i].e_we});
        check("wb_en",    i, {31'd0, o_wb_en}, {31'd0, tv[i].e_wb});
        check("be",       i, {28'd0, o_be},    {28'd0, tv[i].e_be});
        check("data",     i, o_data,           tv[i].e_data);
        check("misalign", i, {31'd0, o_mis},   {31'd0, tv[i].e_mis});
        check("fwd_valid",i, {31'd0, o_fv},    {31'd0, tv[i].e_fv});
        check("load_pend",i, {31'd0, o_lp},    {31'd0, tv[i].e_lp});
        check("mem_addr", i, o_addr,           tv[i].e_addr);
        check("fwd_data", i, o_fdata,          tv[i].e_addr);
        check("fwd_rd",   i, {27'd0, o_frd},   {27'd0, tv[i].e_rd});
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 5'd0);
        //        rst st fl v  wb we opc   f3    addr        rs2           rd     ev we wb be     data          mis fv lp eaddr       erd
        tv[0]  = '{0, 0, 0, 1, 0, 1, OP_S, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0,  0, 0, 0, 4'h0, 32'h0,        0, 0, 0, 32'h0,   5'd0};
        tv[1]  = '{0, 0, 0, 1, 0, 1, OP_S, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0,  0, 0, 0, 4'h0, 32'h0,        0, 0, 0, 32'h0,   5'd0};
        tv[2]  = '{1, 0, 0, 1, 0, 1, OP_S, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0,  1, 1, 0, 4'hF, 32'hDEADBEEF, 0, 0, 0, 32'h100, 5'd0};
        tv[3]  = '{1, 0, 0, 1, 0, 1, OP_S, 3'd0, 32'h103, 32'h000000A5, 5'd0,  1, 1, 0, 4'h8, 32'hA5A5A5A5, 0, 0, 0, 32'h103, 5'd0};
        tv[4]  = '{1, 0, 0, 1, 0, 1, OP_S, 3'd1, 32'h101, 32'h00001234, 5'd0,  1, 0, 0, 4'h0, 32'h12341234, 1, 0, 0, 32'h101, 5'd0};
        tv[5]  = '{1, 0, 0, 1, 1, 0, OP_L, 3'd2, 32'h102, 32'h00000011, 5'd3,  1, 0, 0, 4'h0, 32'h11,       1, 0, 0, 32'h102, 5'd3};
        tv[6]  = '{1, 0, 0, 1, 0, 1, OP_S, 3'd1, 32'h102, 32'h0000BEEF, 5'd0,  1, 1, 0, 4'hC, 32'hBEEFBEEF, 0, 0, 0, 32'h102, 5'd0};
        tv[7]  = '{1, 0, 0, 1, 1, 0, OP_L, 3'd5, 32'h100, 32'h00000077, 5'd4,  1, 0, 1, 4'h3, 32'h77,       0, 0, 1, 32'h100, 5'd4};
        tv[8]  = '{1, 0, 0, 1, 1, 0, OP_L, 3'd0, 32'h101, 32'h00000000, 5'd2,  1, 0, 1, 4'h2, 32'h0,        0, 0, 1, 32'h101, 5'd2};
        tv[9]  = '{1, 0, 0, 1, 1, 0, OP_R, 3'd0, 32'h55,  32'h00000009, 5'd7,  1, 0, 1, 4'h0, 32'h9,        0, 1, 0, 32'h55,  5'd7};
        tv[10] = '{1, 1, 0, 1, 0, 1, OP_S, 3'd2, 32'h400, 32'hFFFFFFFF, 5'd9,  1, 0, 1, 4'h0, 32'h9,        0, 1, 0, 32'h55,  5'd7};
        tv[11] = '{1, 1, 0, 1, 0, 1, OP_S, 3'd2, 32'h400, 32'hFFFFFFFF, 5'd9,  1, 0, 1, 4'h0, 32'h9,        0, 1, 0, 32'h55,  5'd7};
        tv[12] = '{1, 1, 0, 1, 0, 1, OP_S, 3'd2, 32'h400, 32'hFFFFFFFF, 5'd9,  1, 0, 1, 4'h0, 32'h9,        0, 1, 0, 32'h55,  5'd7};
        tv[13] = '{1, 0, 0, 1, 1, 0, OP_R, 3'd0, 32'h66,  32'h00000009, 5'd0,  1, 0, 1, 4'h0, 32'h9,        0, 0, 0, 32'h66,  5'd0};
        tv[14] = '{1, 0, 0, 1, 1, 0, OP_L, 3'd2, 32'h200, 32'h00000000, 5'd5,  1, 0, 1, 4'hF, 32'h0,        0, 0, 1, 32'h200, 5'd5};
        tv[15] = '{1, 1, 1, 1, 1, 0, OP_L, 3'd2, 32'h200, 32'h00000000, 5'd5,  0, 0, 0, 4'h0, 32'h0,        0, 0, 0, 32'h0,   5'd0};
        tv[16] = '{1, 0, 0, 0, 1, 1, OP_S, 3'd2, 32'h300, 32'h0000CAFE, 5'd6,  0, 0, 0, 4'h0, 32'h0,        0, 0, 0, 32'h0,   5'd0};
        tv[17] = '{1, 0, 0, 1, 0, 1, OP_S, 3'd3, 32'h0,   32'h00001234, 5'd0,  1, 0, 0, 4'h0, 32'h1234,     0, 0, 0, 32'h0,   5'd0};
        tv[18] = '{1, 0, 0, 1, 0, 1, OP_S, 3'd2, 32'h300, 32'h0000CAFE, 5'd0,  1, 1, 0, 4'hF, 32'hCAFE,     0, 0, 0, 32'h300, 5'd0};
        tv[19] = '{0, 1, 0, 1, 0, 1, OP_S, 3'd2, 32'h300, 32'h0000CAFE, 5'd0,  0, 0, 0, 4'h0, 32'h0,        0, 0, 0, 32'h0,   5'd0};
        tv[20] = '{1, 0, 0, 1, 1, 0, OP_L, 3'd2, 32'h104, 32'h00000000, 5'd0,  1, 0, 1, 4'hF, 32'h0,        0, 0, 0, 32'h104, 5'd0};

        for (int i = 0; i < 21; i++) run_vec(i);

        // SB held through a 3-cycle stall while EX presents a misaligned SH.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, OP_S, 3'd0, 32'h102, 32'h0000003C, 5'd0);
        @(posedge clk); #1;
        check("sb_be", 100, {28'd0, o_be}, 32'h4);
        check("sb_data", 100, o_data, 32'h3C3C3C3C);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, OP_S, 3'd1, 32'h101, 32'h00005A5A, 5'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("hold_be", 101 + k, {28'd0, o_be}, 32'h4);
            check("hold_data", 101 + k, o_data, 32'h3C3C3C3C);
            check("hold_mis", 101 + k, {31'd0, o_mis}, 32'h0);
            check("hold_we", 101 + k, {31'd0, o_we}, 32'h1);
        end
        // Release: the misaligned SH is captured, then a lone flush clears it.
        stall = 1'b0;
        @(posedge clk); #1;
        check("rel_mis", 110, {31'd0, o_mis}, 32'h1);
        check("rel_we", 110, {31'd0, o_we}, 32'h0);
        check("rel_valid", 110, {31'd0, o_valid}, 32'h1);
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush_valid", 111, {31'd0, o_valid}, 32'h0);
        check("flush_mis", 111, {31'd0, o_mis}, 32'h0);
        check("flush_data", 111, o_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline stage register that sits directly upstream of the memory-access stage. Each cycle it captures one executed instruction from EX and presents it to MEM. On the way through it formats store data into byte lanes, generates byte enables and detects misaligned accesses. It also honours stall and flush from the hazard controller and exposes ALU-result forwarding and load-use information back to EX.

## Interface
Parameters:
- none; widths come from `WORD_DATA` (32), `WORD_ADDR` (32), `RISCV_OPCODE` (7), `RISCV_FUNCT3` (3), `RISCV_RD`/`RS1`/`RS2` (5)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ex2exmem_valid_i  in  1  EX slot holds a real instruction
- ex2exmem_wb_en_i  in  1  instruction writes rd
- ex2exmem_we_i  in  1  instruction writes memory
- ex2exmem_data_i  in  32  raw rs2 value (store data)
- ex2exmem_mem_addr_i  in  32  ALU result / effective address
- ex2exmem_opcode_i  in  7  opcode
- ex2exmem_funct3_i  in  3  funct3
- ex2exmem_rd_i, ex2exmem_rs1_i, ex2exmem_rs2_i  in  5 each  register indices
- ctrl2exmem_stall_i  in  1  hold current contents
- ctrl2exmem_flush_i  in  1  replace contents with bubble
- exmem2mem_valid_o  out  1  registered valid
- exmem2mem_wb_en_o, exmem2mem_we_o  out  1 each  gated enables
- exmem2mem_data_o  out  32  lane-replicated store data
- exmem2mem_mem_addr_o  out  32  registered address
- exmem2mem_opcode_o, exmem2mem_funct3_o, exmem2mem_rd_o, exmem2mem_rs1_o, exmem2mem_rs2_o  out  registered copies
- exmem2mem_be_o  out  4  byte enables for the access
- exmem2ctrl_misalign_o  out  1  registered misaligned-access flag
- exmem2ex_fwd_valid_o  out  1  forwardable result present
- exmem2ex_fwd_rd_o  out  5  forwarding destination
- exmem2ex_fwd_data_o  out  32  forwarding value (= exmem2mem_mem_addr_o)
- exmem2ctrl_load_pending_o  out  1  load in stage, rd≠0

## Operation
- **Update priority per edge:** reset > flush > stall > capture.
- **Reset/flush:** all registered outputs become 0. The result is a bubble: valid=0, we=0, wb_en=0, be=0000, misalign=0.
- **Stall:** every register holds its value. Stall while in reset or flush has no effect.
- **Capture with ex2exmem_valid_i=0:** the stage loads a bubble, with the same values as reset.
- **Capture with valid=1, store (opcode `INS_TYPE_S`):**
  - SB: data={4{rs2[7:0]}}, be=0001<<addr[1:0].
  - SH: data={2{rs2[15:0]}}, be=addr[1]?1100:0011.
  - SW: data=rs2, be=1111.
- **Capture with valid=1, load (opcode `INS_TYPE_L`):**
  - LB/LBU: be=0001<<addr[1:0].
  - LH/LHU: be as SH.
  - LW: be=1111.
  - data=rs2 unchanged.
- **Other opcodes:** be=0000, data=rs2 unchanged.
- **Misalignment:**
  - Misaligned when the access is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
  - On a misaligned capture: misalign=1, we=0, wb_en=0, be=0000, valid stays 1, all other fields are captured normally.
- **Unknown funct3 under L/S:** treated as misaligned is NOT required. Instead it produces be=0000, we=0, wb_en=0 and misalign=0.
- **Forwarding outputs:** combinational from registers.
  - fwd_valid = valid & wb_en & rd≠0 & opcode≠`INS_TYPE_L`.
  - fwd_rd = rd, fwd_data = mem_addr.
  - load_pending = valid & opcode=`INS_TYPE_L` & rd≠0 & ~misalign.

## Timing
- Latency is one cycle from the EX inputs to the exmem2mem_* outputs. The stage has no combinational path from input to output.
- All outputs are 0 in the first cycle after rst_n is sampled low.
- Reset asserted mid-stall produces a bubble on the next edge, and the stall is ignored.
- When flush and stall are asserted together, flush wins.
- A held instruction under stall keeps be/data/misalign stable for every stalled cycle.
- Forwarding and load_pending outputs track the registers in the same cycle; they add no extra delay.

## Structure
- Opcode and funct3 codes (`INS_TYPE_L/S`, `INS_LB`…`INS_LHU`, `INS_SB/SH/SW`) come from riscv_define.v. Add `INS_SH` and `INS_SW` if they are absent.
- Add `BYTE_EN` (3:0), `BE_NONE` (4'b0000) and `BE_WORD` (4'b1111) to global.v.
- One combinational sub-module, `store_align`: inputs opcode, funct3, addr[1:0] and rs2; outputs be, the formatted data and misalign. The register stage instantiates it ahead of the capture flops.

## Test plan
- Reset low for 2 cycles with valid EX input → all outputs 0. Release with a SW, addr=0x100, rs2=0xDEADBEEF → next cycle we=1, be=1111, data=0xDEADBEEF.
- SB, addr=0x103, rs2=0x000000A5 → be=1000, data=0xA5A5A5A5, misalign=0.
- SH at addr=0x101 and LW at addr=0x102 → misalign=1, we=0, wb_en=0, be=0000, valid=1.
- ADD result 0x55 to rd=7, followed by a 3-cycle stall → fwd_valid=1, fwd_rd=7, fwd_data=0x55 held for all 4 cycles. Repeat with rd=0 → fwd_valid=0.
- LW to rd=5 → load_pending=1 and fwd_valid=0. Flush and stall together next cycle → bubble, with load_pending=0.
- EX valid=0 with nonzero fields → captured as a bubble, all outputs 0.
